// File: rtl/pwm_fade_controller_if.sv
// Register-write bus and PWM-stage outputs of the fade controller.
// The master writes TARGET/STEP/INTERVAL/FORCE and observes the duty stream;
// the slave (the controller) consumes the writes and drives the duty stream.
interface pwm_fade_controller_if;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       set_cutoff_en;
   logic [7:0] cutoff_value;
   logic [7:0] current_duty;
   logic       busy;
   logic       done;

   modport master (
      output wr_en, wr_addr, wr_data,
      input  set_cutoff_en, cutoff_value, current_duty, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      output set_cutoff_en, cutoff_value, current_duty, busy, done
   );
endinterface

// File: rtl/pwm_fade_controller.sv
// PWM fade controller: ramps the duty value issued to a downstream PWM stage
// from its present value toward a programmed target, one STEP every INTERVAL
// ramp ticks, where a ramp tick occurs once every TICK_DIV clock cycles.
// Each new duty value is handed over with a one-cycle set_cutoff_en strobe.
module pwm_fade_controller #(
   parameter int unsigned TICK_DIV   = 100,
   parameter logic [7:0]  RESET_DUTY = 8'h7f
) (
   input logic                   clk,
   input logic                   reset_n,
   pwm_fade_controller_if.slave  bus
);

   localparam logic [1:0]  ADDR_TARGET   = 2'd0;
   localparam logic [1:0]  ADDR_STEP     = 2'd1;
   localparam logic [1:0]  ADDR_INTERVAL = 2'd2;
   localparam logic [1:0]  ADDR_FORCE    = 2'd3;
   localparam logic [15:0] TICK_LAST     = 16'(TICK_DIV - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic [7:0]  interval_cnt_q, interval_cnt_d;
   logic [7:0]  target_q, target_d;
   logic [7:0]  step_q, step_d;
   logic [7:0]  interval_q, interval_d;
   logic [7:0]  current_duty_q, current_duty_d;
   logic [7:0]  cutoff_value_q, cutoff_value_d;
   logic        set_cutoff_en_q, set_cutoff_en_d;
   logic        done_q, done_d;

   logic        tick;
   logic        step_due;
   logic [7:0]  step_eff;
   logic [7:0]  interval_eff;
   logic [8:0]  up_sum;
   logic signed [8:0] dn_diff;
   logic [7:0]  step_value;

   // Free-running tick divider, step sizing and the clamped next duty value.
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;

      // A programmed 0 would stall the ramp forever, so it behaves as 1.
      step_eff     = (step_q == 8'd0) ? 8'd1 : step_q;
      interval_eff = (interval_q == 8'd0) ? 8'd1 : interval_q;

      // The strobe gate keeps two step strobes from ever landing back to back
      // (only possible with a very small TICK_DIV); the step then simply
      // happens on the following tick because the counter stays saturated.
      step_due = (state_q == ST_RAMP) && tick && !set_cutoff_en_q &&
                 (({1'b0, interval_cnt_q} + 9'd1) >= {1'b0, interval_eff});

      // 9-bit arithmetic so the ramp neither wraps past 8'hFF nor below 0.
      up_sum  = {1'b0, current_duty_q} + {1'b0, step_eff};
      dn_diff = $signed({1'b0, current_duty_q}) - $signed({1'b0, step_eff});

      if (target_q > current_duty_q) begin
         step_value = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
      end else begin
         step_value = (dn_diff <= $signed({1'b0, target_q})) ? target_q : dn_diff[7:0];
      end
   end

   // Next-state logic: register writes take priority over a pending step.
   always_comb begin
      state_d         = state_q;
      interval_cnt_d  = interval_cnt_q;
      target_d        = target_q;
      step_d          = step_q;
      interval_d      = interval_q;
      current_duty_d  = current_duty_q;
      cutoff_value_d  = cutoff_value_q;
      set_cutoff_en_d = 1'b0;
      done_d          = 1'b0;

      // Interval counter advances on ticks while ramping, saturating so a
      // gated step is retried on the next tick.
      if (state_q == ST_RAMP && tick) begin
         if (step_due) begin
            interval_cnt_d = 8'd0;
         end else if (interval_cnt_q != 8'hFF) begin
            interval_cnt_d = interval_cnt_q + 8'd1;
         end
      end

      if (bus.wr_en) begin
         // A write swallows any step due this cycle; the counter restarts.
         if (step_due) begin
            interval_cnt_d = 8'd0;
         end
         case (bus.wr_addr)
            ADDR_TARGET: begin
               target_d       = bus.wr_data;
               interval_cnt_d = 8'd0;
               state_d        = (bus.wr_data != current_duty_q) ? ST_RAMP : ST_IDLE;
            end
            ADDR_STEP: begin
               step_d = bus.wr_data;
            end
            ADDR_INTERVAL: begin
               interval_d = bus.wr_data;
            end
            ADDR_FORCE: begin
               target_d        = bus.wr_data;
               current_duty_d  = bus.wr_data;
               cutoff_value_d  = bus.wr_data;
               set_cutoff_en_d = 1'b1;
               interval_cnt_d  = 8'd0;
               state_d         = ST_IDLE;
            end
            default: begin
            end
         endcase
      end else if (step_due) begin
         current_duty_d  = step_value;
         cutoff_value_d  = step_value;
         set_cutoff_en_d = 1'b1;
         if (step_value == target_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
      end
   end

   // State and output registers; reset aborts any ramp immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         tick_cnt_q      <= 16'd0;
         interval_cnt_q  <= 8'd0;
         target_q        <= RESET_DUTY;
         step_q          <= 8'd1;
         interval_q      <= 8'd1;
         current_duty_q  <= RESET_DUTY;
         cutoff_value_q  <= RESET_DUTY;
         set_cutoff_en_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         tick_cnt_q      <= tick_cnt_d;
         interval_cnt_q  <= interval_cnt_d;
         target_q        <= target_d;
         step_q          <= step_d;
         interval_q      <= interval_d;
         current_duty_q  <= current_duty_d;
         cutoff_value_q  <= cutoff_value_d;
         set_cutoff_en_q <= set_cutoff_en_d;
         done_q          <= done_d;
      end
   end

   assign bus.set_cutoff_en = set_cutoff_en_q;
   assign bus.cutoff_value  = cutoff_value_q;
   assign bus.current_duty  = current_duty_q;
   assign bus.busy          = (state_q == ST_RAMP);
   assign bus.done          = done_q;

endmodule

// File: doc/pwm_fade_controller.md
PWM_FADE_CONTROLLER -- requirements
Module: pwm_fade_controller

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100: clk cycles per ramp tick, legal range 1..65535.
REQ-002 The block SHALL have parameter RESET_DUTY, default 8'h7f: duty value loaded at reset, equal to the PWM stage's own reset cutoff.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: register write strobe, sampled on each rising edge of clk.
REQ-006 The block SHALL have port wr_addr, input, 2 bits: 0 = TARGET, 1 = STEP, 2 = INTERVAL, 3 = FORCE.
REQ-007 The block SHALL have port wr_data, input, 8 bits: write data.
REQ-008 The block SHALL have port set_cutoff_en, output, 1 bit: one-cycle load strobe to the downstream PWM stage.
REQ-009 The block SHALL have port cutoff_value, output, 8 bits: duty value to the PWM stage, valid whenever set_cutoff_en=1.
REQ-010 The block SHALL have port current_duty, output, 8 bits: last duty value issued.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the state is RAMP.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a ramp reaches its target.

Function
REQ-013 The tick counter SHALL count 0..TICK_DIV-1, assert an internal tick for one cycle at TICK_DIV-1, and then wrap to 0; it SHALL run freely regardless of state.
REQ-014 A write with wr_en=1 at edge N SHALL update the addressed register, visible from cycle N+1.
REQ-015 A STEP or INTERVAL value of 0 SHALL be treated as 1.
REQ-016 The interval counter SHALL increment on each tick while in RAMP; when it reaches INTERVAL, a step SHALL occur and the counter SHALL clear to 0.
REQ-017 The state machine SHALL have two states, IDLE (current_duty==TARGET) and RAMP.
REQ-018 A TARGET write whose value differs from current_duty SHALL move the state to RAMP and clear the interval counter.
REQ-019 A TARGET write whose value equals current_duty SHALL move the state to IDLE, with no set_cutoff_en and no done.
REQ-020 An upward step SHALL compute min(current+STEP, TARGET) using 9-bit arithmetic, so 8'hFF+STEP never wraps.
REQ-021 A downward step SHALL compute max(current-STEP, TARGET) using 9-bit signed arithmetic, so the result never underflows below 0.
REQ-022 Each step SHALL register the new value into current_duty and cutoff_value and assert set_cutoff_en for exactly one cycle, on the edge after the step tick.
REQ-023 When a step lands on TARGET, done SHALL pulse in the same cycle as that set_cutoff_en, and the state SHALL return to IDLE.
REQ-024 A TARGET write during RAMP SHALL retarget from the present current_duty, including reversing direction; no intermediate duty values SHALL be skipped or repeated.
REQ-025 A FORCE write SHALL load current_duty, TARGET and cutoff_value with wr_data, pulse set_cutoff_en on the next cycle, set the state to IDLE, and produce no done.
REQ-026 A write coinciding with a step tick SHALL take priority: the step SHALL be suppressed and the interval counter cleared.
REQ-027 set_cutoff_en SHALL never be asserted on two consecutive cycles except for back-to-back FORCE writes.
REQ-028 In IDLE, set_cutoff_en SHALL stay low and cutoff_value SHALL hold its value.

Reset
REQ-029 While reset_n=0, the block SHALL asynchronously force: set_cutoff_en=0, done=0, busy=0, and state IDLE.
REQ-030 While reset_n=0, the block SHALL asynchronously force: cutoff_value, current_duty and TARGET to RESET_DUTY; STEP=1; INTERVAL=1; tick and interval counters to 0.
REQ-031 The block SHALL issue no set_cutoff_en after reset release until a register write occurs.
REQ-032 Assertion of reset_n=0 mid-ramp SHALL abort the ramp immediately, with outputs taking their reset values without waiting for a clk edge.

Verification (TICK_DIV=4)
REQ-033 Reset release, then 200 idle cycles -> set_cutoff_en never asserted; cutoff_value=8'h7f; busy=0.
REQ-034 Write STEP=8'h10, then TARGET=8'hA0 -> set_cutoff_en pulses carrying 8'h8F, 8'h9F, 8'hA0, spaced 4 cycles apart; done coincides with 8'hA0; busy then falls.
REQ-035 Write STEP=8'h40, then TARGET=8'h05 -> pulses carry 8'h3F, then 8'h05 (clamped at the target, no underflow); done pulses once.
REQ-036 Write INTERVAL=3, STEP=1, TARGET=8'h82 -> pulses carry 8'h80, 8'h81, 8'h82, spaced 12 cycles apart.
REQ-037 Write STEP=8'h20, TARGET=8'hFF; after the first pulse (8'h9F), write TARGET=8'h70 -> next pulses carry 8'h7F, then 8'h70, with done on 8'h70.
REQ-038 Write FORCE=8'hFF -> a single set_cutoff_en with 8'hFF one cycle after the write; busy=0 and done=0 throughout.
REQ-039 Assert reset_n low mid-ramp, between clk edges -> all outputs at reset values before the next edge.
